memory_mmio: RTL and testbench
==============================

# memory_mmio

Parametrised data memory with a memory-mapped I/O window. It sits on the CPU data port and answers a single address/load/in/out bus. Block RAM occupies the low addresses, and a small register bank sits directly above it: LED output, debounced button levels, sticky button-press flags and a free-running cycle counter. It is the configurable successor to the fixed 8K-RAM + one-LED + one-button data memory.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- RAM_DEPTH, 8192, RAM words; also the I/O base address (IO_BASE)
- NUM_LED, 1, LED outputs (1..DATA_W)
- NUM_BTN, 1, button inputs (1..DATA_W)
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a level is accepted (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- address  in  ADDR_W  word address
- load  in  1  write enable
- in  in  DATA_W  write data
- out  out  DATA_W  registered read data
- led  out  NUM_LED  LED drive, equals LED register [NUM_LED-1:0]
- btn  in  NUM_BTN  raw asynchronous buttons

## Operation
Address map:
- 0..RAM_DEPTH-1: RAM, read/write.
- IO_BASE+0: LED register. Read/write; only bits [NUM_LED-1:0] are stored, other bits read 0.
- IO_BASE+1: debounced button levels. Read-only; 1 = pressed after polarity correction. Writes are ignored.
- IO_BASE+2: press flags. A bit sets on a debounced 0→1 transition. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- IO_BASE+3: cycle counter. Increments by 1 every cycle and wraps at 2^DATA_W. A write loads `in`, and counting resumes from that value on the next cycle.
- Any other address: reads 0, writes are ignored.

Button path, per button:
- Two-flop synchroniser, reset to the released level.
- Debounce counter: increments on each edge where the synchronised level ≠ the debounced level. It clears when the two are equal.
- When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never reaches the debounced level.
- Press flag: if a set and a W1C clear hit the same bit in the same cycle, the set wins.

## Timing
- Write: takes effect at the rising edge where load=1.
- Read: `out` is registered. It reflects `address` sampled at edge k and is valid after edge k, a latency of 1.
- Read-during-write to the same address returns the old value (read-first), for RAM and for every I/O register.
- Button: a raw level change first sampled at edge k appears in the debounced level at edge k+1+DEBOUNCE_CYCLES, provided it stays stable. The press flag sets on that same edge.
- Reset values: out=0, LED register=0, led=0, debounced levels=0, press flags=0, cycle counter=0, debounce counters=0, synchronisers at the released level.
- RAM contents are not reset and are undefined until written.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). A write in the same cycle is lost. RAM keeps its contents.
- Address width rules: the RAM index is address[$clog2(RAM_DEPTH)-1:0], used only when address < RAM_DEPTH. I/O decode compares the full ADDR_W address.

## Structure
- Package memory_mmio_pkg holds:
  - register offsets LED_OFS=0, BTN_LVL_OFS=1, BTN_PRESS_OFS=2, CYC_OFS=3;
  - IO_WINDOW=4;
  - an address-decode enum: RAM, LED, BTN_LVL, BTN_PRESS, CYC, NONE.
- Sub-module btn_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated NUM_BTN times with a generate loop.
- The RAM is an inferred synchronous array in the top level. Read mux and register bank also live in the top level.

## Test plan
Run with RAM_DEPTH=8192, NUM_LED=4, NUM_BTN=2, DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1.

1. Reset, then read 8192, 8193, 8194 → out=0 each. Check led=4'b0000 throughout reset.
2. Write 12345 to address 0 and -1 to address 8191. Read both back → 12345 and -1 one cycle after address. Read address 0 in the same cycle as a write of 7 to address 0 → returns 12345 (old value); the next read returns 7.
3. Write 16'hFFFF to 8192 → led=4'b1111, readback=16'h000F. Write to 8197 (unmapped) → read returns 0 and no state changes.
4. Drive btn[0]=0 (pressed) at edge k → read of 8193 shows bit0=1 only from edge k+5 onward, and read of 8194 shows 1. Then write 1 to 8194 → flag reads 0.
5. Pulse btn[1] low for 3 cycles → levels and flags stay 0. Hold btn[1] low so the flag set coincides with a W1C write of 2 to 8194 → flag reads 1 (set wins).
6. Write 16'hFFFE to 8195 → reads show FFFF, then 0000, confirming wrap. Assert rst_n mid-count → counter, LED register and flags read 0, while RAM address 0 still holds 7.

Source files
------------

// File: rtl/memory_mmio_pkg.sv
// memory_mmio shared definitions: I/O register offsets
// and the address-decode enum.
package memory_mmio_pkg;

  localparam int LED_OFS       = 0;
  localparam int BTN_LVL_OFS   = 1;
  localparam int BTN_PRESS_OFS = 2;
  localparam int CYC_OFS       = 3;
  localparam int IO_WINDOW     = 4;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_LED,
    DEC_BTN_LVL,
    DEC_BTN_PRESS,
    DEC_CYC,
    DEC_NONE
  } dec_e;

endpackage

// File: rtl/memory_mmio_btn.sv
// btn_debounce: two-flop synchroniser, stability counter
// and a one-cycle pulse on a debounced press.
module btn_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int   CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic REL = (ACTIVE_LOW != 0);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;
  logic          w_diff;
  logic          w_done;

  assign w_pressed = r_sync2 ^ REL;
  assign w_diff    = w_pressed != r_level;
  // The edge that would take the count to DEBOUNCE_CYCLES flips the level.
  assign w_done    = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= REL;
      r_sync2 <= REL;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_done & w_pressed;

endmodule

// File: rtl/memory_mmio.sv
// memory_mmio: block RAM plus an LED / button / cycle-counter
// register bank mapped directly above it.
module memory_mmio
  import memory_mmio_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int RAM_DEPTH       = 8192,
  parameter int NUM_LED         = 1,
  parameter int NUM_BTN         = 1,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  address,
  input  logic               load,
  input  logic [DATA_W-1:0]  in,
  output logic [DATA_W-1:0]  out,
  output logic [NUM_LED-1:0] led,
  input  logic [NUM_BTN-1:0] btn
);

  localparam int AXW    = ADDR_W + 1;
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [AXW-1:0] IO_BASE_X = AXW'(RAM_DEPTH);

  logic [AXW-1:0]    w_addr_x;
  logic [AXW-1:0]    w_ofs;
  logic [RAM_AW-1:0] w_ram_idx;
  dec_e              w_dec;
  dec_e              r_dec_q;

  logic [DATA_W-1:0] r_ram [RAM_DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] w_io_rd;
  logic [DATA_W-1:0] r_io_q;
  logic [DATA_W-1:0] r_cyc;

  logic [NUM_LED-1:0] r_led;
  logic [NUM_BTN-1:0] w_lvl;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] r_press;

  assign w_addr_x  = {1'b0, address};
  assign w_ofs     = w_addr_x - IO_BASE_X;
  assign w_ram_idx = address[RAM_AW-1:0];

  always_comb begin
    w_dec = DEC_NONE;
    if (w_addr_x < IO_BASE_X) begin
      w_dec = DEC_RAM;
    end else if (w_ofs < AXW'(IO_WINDOW)) begin
      unique case (1'b1)
        w_ofs == AXW'(LED_OFS):       w_dec = DEC_LED;
        w_ofs == AXW'(BTN_LVL_OFS):   w_dec = DEC_BTN_LVL;
        w_ofs == AXW'(BTN_PRESS_OFS): w_dec = DEC_BTN_PRESS;
        w_ofs == AXW'(CYC_OFS):       w_dec = DEC_CYC;
        default:                      w_dec = DEC_NONE;
      endcase
    end
  end

  // Read-first RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (load && w_dec == DEC_RAM) begin
      r_ram[w_ram_idx] <= in;
    end
    r_ram_q <= r_ram[w_ram_idx];
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .ACTIVE_LOW      (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn[g]),
      .o_level (w_lvl[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_clr = (load && w_dec == DEC_BTN_PRESS) ?
                 in[NUM_BTN-1:0] : '0;

  always_comb begin
    w_io_rd = '0;
    case (w_dec)
      DEC_LED:       w_io_rd[NUM_LED-1:0] = r_led;
      DEC_BTN_LVL:   w_io_rd[NUM_BTN-1:0] = w_lvl;
      DEC_BTN_PRESS: w_io_rd[NUM_BTN-1:0] = r_press;
      DEC_CYC:       w_io_rd = r_cyc;
      default:       w_io_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_q <= DEC_NONE;
      r_io_q  <= '0;
      r_led   <= '0;
      r_press <= '0;
      r_cyc   <= '0;
    end else begin
      r_dec_q <= w_dec;
      r_io_q  <= w_io_rd;
      if (load && w_dec == DEC_LED) begin
        r_led <= in[NUM_LED-1:0];
      end
      // A press arriving with a clear of the same bit wins.
      r_press <= (r_press & ~w_clr) | w_rise;
      if (load && w_dec == DEC_CYC) begin
        r_cyc <= in;
      end else begin
        r_cyc <= r_cyc + DATA_W'(1);
      end
    end
  end

  // A reset dec of DEC_NONE steers out to the zeroed I/O register.
  assign out = (r_dec_q == DEC_RAM) ? r_ram_q : r_io_q;
  assign led = r_led;

endmodule

// File: tb/tb_memory_mmio.sv
// Self-checking bench for memory_mmio against a behavioural
// model of the address map and the button debounce rule.
module tb_memory_mmio;

  localparam int DEPTH = 8192;
  localparam int DB    = 4;
  localparam logic [15:0] A_LED = 16'd8192;
  localparam logic [15:0] A_LVL = 16'd8193;
  localparam logic [15:0] A_PRS = 16'd8194;
  localparam logic [15:0] A_CYC = 16'd8195;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic [3:0]  led;
  logic [1:0]  btn = 2'b11;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_ram [DEPTH];
  bit          m_ok  [DEPTH];
  logic [3:0]  m_led;
  logic [1:0]  m_lvl;
  logic [1:0]  m_press;
  logic [15:0] m_cyc;
  logic [1:0]  m_hist [0:DB];

  memory_mmio #(
    .DATA_W(16), .ADDR_W(16), .RAM_DEPTH(DEPTH),
    .NUM_LED(4), .NUM_BTN(2), .BTN_ACTIVE_LOW(1),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address),
    .load(load), .in(in), .out(out), .led(led), .btn(btn)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_led = '0;
    m_lvl = '0;
    m_press = '0;
    m_cyc = '0;
    for (int j = 0; j <= DB; j++) m_hist[j] = '0;
  endfunction

  function automatic void model_read(input logic [15:0] a,
                                     output logic [15:0] e,
                                     output bit k);
    k = 1'b1;
    e = '0;
    if (a < A_LED) begin
      e = m_ram[a[12:0]];
      k = m_ok[a[12:0]];
    end else if (a == A_LED) e = {12'b0, m_led};
    else if (a == A_LVL) e = {14'b0, m_lvl};
    else if (a == A_PRS) e = {14'b0, m_press};
    else if (a == A_CYC) e = m_cyc;
  endfunction

  // m_hist[0] is the newest pressed-level sample; a level is accepted
  // once DB consecutive synchronised samples agree on a new value.
  function automatic void model_edge(input logic [15:0] a, input logic ld,
                                     input logic [15:0] d,
                                     input logic [1:0] raw);
    logic [1:0] rise;
    logic [1:0] clr;
    bit stable;
    rise = '0;
    for (int b = 0; b < 2; b++) begin
      stable = 1'b1;
      for (int j = 2; j <= DB; j++)
        if (m_hist[j][b] != m_hist[1][b]) stable = 1'b0;
      if (stable && m_hist[1][b] != m_lvl[b]) begin
        m_lvl[b] = m_hist[1][b];
        rise[b] = m_lvl[b];
      end
    end
    for (int j = DB; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = ~raw;
    clr = (ld && a == A_PRS) ? d[1:0] : 2'b00;
    m_press = (m_press & ~clr) | rise;
    if (ld && a < A_LED) begin
      m_ram[a[12:0]] = d;
      m_ok[a[12:0]] = 1'b1;
    end
    if (ld && a == A_LED) m_led = d[3:0];
    m_cyc = (ld && a == A_CYC) ? d : m_cyc + 16'd1;
  endfunction

  task automatic bus(input logic [15:0] a, input logic ld,
                     input logic [15:0] d,
                     output logic [15:0] e, output bit k);
    address = a;
    load = ld;
    in = d;
    model_read(a, e, k);
    model_edge(a, ld, d, btn);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    bit k;
    rst_n = 1'b0;
    btn = 2'b11;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out !== 16'h0 || led !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_hold: out=%h led=%b want 0000/0000", out, led);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus(A_LED + 16'(i), 1'b0, '0, e, k);
      vectors++;
      if (out !== 16'h0 || out !== e) begin
        miscompares++;
        $display("FAIL reset_rd%0d: out=%h want 0000", i, out);
      end
    end
  endtask

  task automatic test_ram();
    logic [15:0] e, a, d;
    logic [15:0] want [4];
    logic [15:0] wa [4];
    bit k, ld;
    want[0] = 16'd12345; want[1] = 16'hFFFF;
    want[2] = 16'd12345; want[3] = 16'd7;
    wa[0] = 16'd0; wa[1] = 16'd8191; wa[2] = 16'd0; wa[3] = 16'd0;
    bus(16'd0, 1'b1, 16'd12345, e, k);
    bus(16'd8191, 1'b1, 16'hFFFF, e, k);
    for (int i = 0; i < 4; i++) begin
      bus(wa[i], i == 2, 16'd7, e, k);
      vectors++;
      if (out !== want[i] || out !== e) begin
        miscompares++;
        $display("FAIL ram_rd%0d: out=%h want %h", i, out, want[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 15))
                                      : 16'($urandom_range(8176, 8191));
      ld = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      bus(a, ld, d, e, k);
      if (k) begin
        vectors++;
        if (out !== e) begin
          miscompares++;
          $display("FAIL ram_rand a=%0d: out=%h want %h", a, out, e);
        end
      end
    end
  endtask

  task automatic test_led();
    logic [15:0] e;
    logic [15:0] ra [3];
    logic [15:0] rw [3];
    bit k;
    ra[0] = 16'd8197; ra[1] = A_LED; ra[2] = 16'd0;
    rw[0] = 16'h0000; rw[1] = 16'h000F; rw[2] = 16'd7;
    bus(A_LED, 1'b1, 16'hFFFF, e, k);
    vectors++;
    if (led !== 4'b1111) begin
      miscompares++;
      $display("FAIL led_pin: led=%b want 1111", led);
    end
    bus(16'd8197, 1'b1, 16'h1234, e, k);
    for (int i = 0; i < 3; i++) begin
      bus(ra[i], 1'b0, '0, e, k);
      vectors++;
      if (out !== rw[i] || out !== e || led !== 4'b1111) begin
        miscompares++;
        $display("FAIL led_rd%0d: out=%h led=%b want %h/1111",
                 i, out, led, rw[i]);
      end
    end
  endtask

  task automatic test_button_press();
    logic [15:0] e;
    bit k;
    int first = -1;
    btn[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(A_LVL, 1'b0, '0, e, k);
      vectors++;
      if (out !== e) begin
        miscompares++;
        $display("FAIL btn_lvl%0d: out=%h want %h", i, out, e);
      end
      if (first < 0 && out[0] === 1'b1) first = i;
    end
    vectors++;
    if (first != 6) begin
      miscompares++;
      $display("FAIL btn_latency: first=%0d want 6", first);
    end
    bus(A_PRS, 1'b0, '0, e, k);
    vectors++;
    if (out !== 16'h0001 || out !== e) begin
      miscompares++;
      $display("FAIL btn_flag: out=%h want 0001", out);
    end
    bus(A_PRS, 1'b1, 16'h0001, e, k);
    bus(A_PRS, 1'b0, '0, e, k);
    vectors++;
    if (out !== 16'h0000 || out !== e) begin
      miscompares++;
      $display("FAIL btn_w1c: out=%h want 0000", out);
    end
  endtask

  task automatic test_glitch_set_wins();
    logic [15:0] e;
    bit k;
    btn[1] = 1'b0;
    for (int i = 0; i < 3; i++) bus(A_LVL, 1'b0, '0, e, k);
    btn[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus((i % 2 == 0) ? A_LVL : A_PRS, 1'b0, '0, e, k);
      vectors++;
      if (out !== e || out[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch%0d: out=%h want %h", i, out, e);
      end
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 5; i++) bus(A_LVL, 1'b0, '0, e, k);
    bus(A_PRS, 1'b1, 16'h0002, e, k);
    bus(A_PRS, 1'b0, '0, e, k);
    vectors++;
    if (out !== 16'h0002 || out !== e) begin
      miscompares++;
      $display("FAIL set_wins: out=%h want 0002", out);
    end
  endtask

  task automatic test_random_mixed();
    logic [15:0] e, a, d;
    bit k, ld;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 1)] ^= 1'b1;
      a = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 15))
                                      : 16'($urandom_range(8192, 8199));
      ld = ($urandom_range(0, 3) == 0);
      d = 16'($urandom);
      bus(a, ld, d, e, k);
      if (k) begin
        vectors++;
        if (out !== e) begin
          miscompares++;
          $display("FAIL mixed a=%0d: out=%h want %h", a, out, e);
        end
      end
    end
  endtask

  task automatic test_cycle_and_reset();
    logic [15:0] e;
    logic [15:0] want [3];
    logic [15:0] ra [4];
    logic [15:0] rw [4];
    bit k;
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
    ra[0] = A_CYC; ra[1] = A_LED; ra[2] = A_PRS; ra[3] = 16'd0;
    rw[0] = 16'h0; rw[1] = 16'h0; rw[2] = 16'h0; rw[3] = 16'd7;
    bus(A_CYC, 1'b1, 16'hFFFE, e, k);
    for (int i = 0; i < 3; i++) begin
      bus(A_CYC, 1'b0, '0, e, k);
      vectors++;
      if (out !== want[i] || out !== e) begin
        miscompares++;
        $display("FAIL cyc%0d: out=%h want %h", i, out, want[i]);
      end
    end
    bus(A_LED, 1'b1, 16'h0005, e, k);
    bus(A_CYC, 1'b0, '0, e, k);
    #2;
    rst_n = 1'b0;
    address = A_LED;
    load = 1'b1;
    in = 16'hFFFF;
    model_reset();
    #1;
    vectors++;
    if (out !== 16'h0 || led !== 4'h0) begin
      miscompares++;
      $display("FAIL async_rst: out=%h led=%b want 0000/0000", out, led);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (led !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_wr_lost: led=%b want 0000", led);
    end
    load = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus(ra[i], 1'b0, '0, e, k);
      vectors++;
      if (out !== rw[i] || out !== e) begin
        miscompares++;
        $display("FAIL post_rst%0d: out=%h want %h", i, out, rw[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_button_press();
    test_glitch_set_wins();
    test_random_mixed();
    test_cycle_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
